// File: rtl/instr_decode_queue.sv
// instr_decode_queue
//   Buffers fetched instruction words in a DEPTH-entry circular FIFO and
//   presents one decoded instruction (opcode, rs, imm) in an output register.
//   Valid/ready handshakes on both sides; flush discards everything queued
//   and presented (branch redirect).
//
// Optional build macro: QUEUE_BYPASS_EN
//   When defined, a word arriving at an empty queue whose output register
//   can load is decoded straight into the output register (1-edge latency).
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high
//   flush      synchronous discard of queue contents and presented instruction
//   in_valid   in_instr is valid
//   in_ready   queue can accept (count != DEPTH)
//   in_instr   instruction word
//   out_valid  decoded fields valid
//   out_ready  consumer takes the presented instruction
//   opcode     instr[INSTR_W-1 -: OP_W]
//   rs         instr[INSTR_W-OP_W-1 -: RS_W]
//   imm        instr[INSTR_W-OP_W-1:0]
//   count      FIFO occupancy, output register excluded
module instr_decode_queue #(
   parameter int INSTR_W = 8,
   parameter int OP_W    = 3,
   parameter int RS_W    = 2,
   parameter int DEPTH   = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [INSTR_W-1:0]         in_instr,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [OP_W-1:0]            opcode,
   output logic [RS_W-1:0]            rs,
   output logic [INSTR_W-OP_W-1:0]    imm,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [INSTR_W-1:0] mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;

   logic               load_ok;
   logic               push_acc;
   logic               bypass;
   logic               do_push;
   logic               do_pop;
   logic [INSTR_W-1:0] src_word;

   assign in_ready = (count != CW'(DEPTH));
   assign load_ok  = !out_valid || out_ready;
   assign push_acc = in_valid && in_ready;

`ifdef QUEUE_BYPASS_EN
   assign bypass = (count == '0) && load_ok && push_acc;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed word goes straight to the output register, never the FIFO.
   assign do_push = push_acc && !bypass;
   assign do_pop  = load_ok && (count != '0);

   always_comb begin
      src_word = in_instr;
      if (do_pop)
         src_word = mem[rd_ptr];
   end

   // Storage array carries no reset; pointers/count define its validity.
   always_ff @(posedge clock) begin
      if (!reset && !flush && do_push)
         mem[wr_ptr] <= in_instr;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         out_valid <= 1'b0;
         opcode    <= '0;
         rs        <= '0;
         imm       <= '0;
      end else if (flush) begin
         // Field registers deliberately keep their last values.
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         out_valid <= 1'b0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);

         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase

         if (load_ok) begin
            if (do_pop || bypass) begin
               out_valid <= 1'b1;
               opcode    <= src_word[INSTR_W-1 -: OP_W];
               rs        <= src_word[INSTR_W-OP_W-1 -: RS_W];
               imm       <= src_word[INSTR_W-OP_W-1:0];
            end else begin
               out_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_decode_queue.sv
// Self-checking bench for instr_decode_queue (default parameters).
// Honours QUEUE_BYPASS_EN in its reference model and directed table.
module tb_instr_decode_queue;

   localparam int DEPTH = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       flush = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_instr = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [2:0] opcode;
   logic [1:0] rs;
   logic [4:0] imm;
   logic [2:0] count;

   instr_decode_queue #(.INSTR_W(8), .OP_W(3), .RS_W(2), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .out_valid(out_valid), .out_ready(out_ready),
      .opcode(opcode), .rs(rs), .imm(imm), .count(count)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: a queue of words plus the presented word.
   logic [7:0] mq[$];
   bit         m_ov   = 1'b0;
   logic [7:0] m_word = '0;
   int         ff_seen = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input bit r, input bit f, input bit iv,
                             input logic [7:0] w, input bit ordy);
      bit acc, load;
      if (r) begin
         mq.delete(); m_ov = 0; m_word = '0;
      end else if (f) begin
         mq.delete(); m_ov = 0;
      end else begin
         acc  = iv && (mq.size() != DEPTH);
         load = !m_ov || ordy;
`ifdef QUEUE_BYPASS_EN
         if (mq.size() == 0 && load && acc) begin
            m_word = w; m_ov = 1;
            return;
         end
`endif
         if (load) begin
            if (mq.size() > 0) begin
               m_word = mq.pop_front(); m_ov = 1;
            end else begin
               m_ov = 0;
            end
         end
         if (acc) mq.push_back(w);
      end
   endtask

   // Apply one cycle of inputs, step the model, compare all outputs.
   task automatic step(input bit r, input bit f, input bit iv,
                       input logic [7:0] w, input bit ordy);
      reset = r; flush = f; in_valid = iv; in_instr = w; out_ready = ordy;
      #0;
      chk("in_ready_pre", int'(in_ready), int'(mq.size() != DEPTH));
      @(posedge clock);
      model_edge(r, f, iv, w, ordy);
      #1;
      chk("out_valid", int'(out_valid), int'(m_ov));
      chk("opcode", int'(opcode), int'(m_word[7:5]));
      chk("rs", int'(rs), int'(m_word[4:3]));
      chk("imm", int'(imm), int'(m_word[4:0]));
      chk("count", int'(count), mq.size());
      chk("in_ready", int'(in_ready), int'(mq.size() != DEPTH));
      if (out_valid && opcode == 3'd7 && imm == 5'h1F) ff_seen++;
   endtask

   // Offer a word until accepted (bounded).
   task automatic push_word(input logic [7:0] w, input bit ordy);
      bit acc;
      for (int k = 0; k < 20; k++) begin
         acc = (mq.size() != DEPTH);
         step(0, 0, 1, w, ordy);
         if (acc) return;
      end
      chk("push_timeout", 1, 0);
   endtask

   task automatic idle(input int n, input bit ordy);
      for (int k = 0; k < n; k++) step(0, 0, 0, 8'h00, ordy);
   endtask

   typedef struct {
      bit         r;
      bit         f;
      bit         iv;
      logic [7:0] w;
      bit         ordy;
      bit         e_ov;
      int         e_op;
      int         e_rs;
      int         e_imm;
      int         e_cnt;
   } vec_t;

   vec_t tbl[4];

   initial begin
      logic [7:0] seq1 [5];
      seq1 = '{8'h01, 8'h22, 8'h43, 8'h64, 8'h85};

      // 0xB3 = 101_10_011 -> opcode 5, rs 2, imm 0x13
      tbl[0] = '{1, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0};
`ifdef QUEUE_BYPASS_EN
      tbl[1] = '{0, 0, 1, 8'hB3, 1, 1, 5, 2, 8'h13, 0};
      tbl[2] = '{0, 0, 0, 8'h00, 1, 0, 5, 2, 8'h13, 0};
      tbl[3] = '{0, 0, 0, 8'h00, 1, 0, 5, 2, 8'h13, 0};
`else
      tbl[1] = '{0, 0, 1, 8'hB3, 1, 0, 0, 0, 8'h00, 1};
      tbl[2] = '{0, 0, 0, 8'h00, 1, 1, 5, 2, 8'h13, 0};
      tbl[3] = '{0, 0, 0, 8'h00, 1, 0, 5, 2, 8'h13, 0};
`endif
      foreach (tbl[i]) begin
         step(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].w, tbl[i].ordy);
         chk("tbl_out_valid", int'(out_valid), int'(tbl[i].e_ov));
         chk("tbl_opcode", int'(opcode), tbl[i].e_op);
         chk("tbl_rs", int'(rs), tbl[i].e_rs);
         chk("tbl_imm", int'(imm), tbl[i].e_imm);
         chk("tbl_count", int'(count), tbl[i].e_cnt);
      end

      // Fill with consumer stalled, then drain in order, then wrap pointers.
      for (int i = 0; i < 5; i++) push_word(seq1[i], 0);
      idle(2, 0);
      chk("full_in_ready", int'(in_ready), 0);
      chk("full_count", int'(count), DEPTH);
      idle(7, 1);
      for (int i = 0; i < 8; i++) push_word(8'(8'h10 + 8'(i * 37)), 1);
      idle(6, 1);

      // Stall: presented fields held while queue fills and stops at DEPTH.
      push_word(8'hC9, 0);
      idle(1, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 8'(8'h30 + 8'(i)), 0);
      chk("stall_count", int'(count), DEPTH);
      chk("stall_opcode", int'(opcode), 6);
      idle(7, 1);

      // Flush with count=3, out_valid=1, 0xFF offered.
      step(1, 0, 0, 8'h00, 0);
      for (int i = 0; i < 4; i++) push_word(8'(8'h41 + 8'(i)), 0);
      chk("preflush_count", int'(count), 3);
      step(0, 1, 1, 8'hFF, 0);
      chk("flush_count", int'(count), 0);
      chk("flush_out_valid", int'(out_valid), 0);
      idle(6, 1);
      chk("ff_never_out", ff_seen, 0);

      // Reset mid-stall with flush and push in the same cycle.
      for (int i = 0; i < 3; i++) push_word(8'(8'h51 + 8'(i)), 0);
      step(1, 1, 1, 8'hAA, 0);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_count", int'(count), 0);

      // Randomised traffic against the model.
      for (int i = 0; i < 2000; i++) begin
         step(($urandom_range(199) == 0), ($urandom_range(29) == 0),
              ($urandom_range(9) < 7), 8'($urandom), ($urandom_range(9) < 6));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
